adc_multichannel_reader: RTL and testbench
==========================================

Name: adc_multichannel_reader

Overview:
Parametrised successor to the single-channel serial ADC readout. Generates the ADC conversion clock and SCLK from clk_50MHz and captures NUM_CHANNELS parallel DOUT lines that share SCLK and DRDY_Bar. Optionally box-car averages 2^AVG_POWER frames per channel, then presents one wide word with a single-cycle valid strobe to the Raman control logic. All logic runs in the clk_50MHz domain; SCLK is a generated output, never used as a clock.

Parameters:
DATA_WIDTH, 16, bits per ADC frame, MSB first, two's complement
NUM_CHANNELS, 2, parallel DOUT lines captured simultaneously
SCLK_DIV_POWER, 0, SCLK = clk_50MHz / 2^(SCLK_DIV_POWER+1); 0 gives 25 MHz, max 3
AVG_POWER, 0, frames averaged = 2^AVG_POWER; 0 means no averaging, max 8

Ports:
clk_50MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
CLK  output  1  ADC conversion clock, identical to SCLK
SCLK  output  1  serial clock
DRDY_Bar  input  1  ADC data-ready, asynchronous to clk_50MHz
DOUT  input  NUM_CHANNELS  serial data, bit i is channel i
overrun_clear  input  1  clears the sticky overrun flag
FLAG__New_Data  output  1  one-cycle strobe, DATA valid
DATA  output  NUM_CHANNELS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
overrun  output  1  sticky: DRDY_Bar edge arrived while a frame was being read
frame_count  output  16  frames captured since reset, wraps at 0xFFFF

Behaviour:
- Reset: divider 0, SCLK/CLK 0, state IDLE, shift registers, accumulators, DATA 0, FLAG__New_Data 0, overrun 0, frame_count 0. Reset mid-frame discards the partial frame and partial average.
- Divider: free-running counter; SCLK = cnt[SCLK_DIV_POWER]. fall_tick asserts for the clk_50MHz cycle in which cnt[SCLK_DIV_POWER:0] is all ones, i.e. the cycle before the SCLK falling edge. All DOUT and DRDY sampling happens only on fall_tick.
- DRDY_Bar passes through a 2-flop synchroniser. drdy_rise = synchronised DRDY_Bar high on this fall_tick and low on the previous one.
- IDLE: on fall_tick with drdy_rise, shift in DOUT as bit 1 of DATA_WIDTH, set bit_cnt=1, and go to READ.
- READ: on each fall_tick, shift DOUT into each channel's register, left shift, LSB in. When bit_cnt reaches DATA_WIDTH-1, the final bit is shifted in and the state goes to ACCUM. A drdy_rise in READ sets overrun and is otherwise ignored; it does not restart the frame.
- ACCUM (one clk): sign-extend each frame into its accumulator, width DATA_WIDTH+AVG_POWER; increment frame_count. If avg_cnt = 2^AVG_POWER-1, go to OUTPUT, else increment avg_cnt and go to IDLE.
- OUTPUT (one clk): DATA[i] = accumulator[i] arithmetic right-shifted by AVG_POWER, truncated toward minus infinity. FLAG__New_Data=1 for exactly this cycle. Clear accumulators and avg_cnt, then go to IDLE.
- Latency: FLAG__New_Data is asserted 2 clk_50MHz cycles after the fall_tick that captured the final bit of the final frame. DATA holds its value until the next OUTPUT.
- overrun: set and overrun_clear in the same cycle leaves overrun set. Set takes priority.
- frame_count wraps from 0xFFFF to 0 silently.

Decomposition:
- Shared package adc_pkg holds the state encoding (IDLE, READ, ACCUM, OUTPUT), MAX_SCLK_DIV_POWER=3, MAX_AVG_POWER=8, and a frame_count width constant of 16.
- One natural sub-module, adc_sclk_divider: counter, SCLK, fall_tick.
- The per-channel shift/accumulate is a generate loop, not a separate module.

Test Plan:
1. Defaults. Drive DRDY_Bar rising edge, then ch0 0xA5C3 and ch1 0x1234 MSB first on fall_ticks. Expect DATA=0x1234A5C3, one FLAG__New_Data pulse, frame_count=1.
2. AVG_POWER=2, ch0 frames 100, 200, 300, 400. Expect exactly one strobe, after the 4th frame, with ch0=250. No strobe after frames 1-3.
3. AVG_POWER=2, ch0 frames -4, -4, -4, -3 (sum -15). Expect ch0=0xFFFC (-4, floor rounding).
4. Second DRDY_Bar rising edge at bit 8 of a frame. Expect the frame to complete unchanged and overrun=1. Pulse overrun_clear: expect overrun=0 next cycle.
5. SCLK_DIV_POWER=1: measure an SCLK period of 4 clk_50MHz cycles. Assert reset at bit 10, then capture a full frame 0x00FF. Expect DATA ch0=0x00FF, no strobe from the aborted frame, frame_count=1.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the multichannel serial ADC reader.
package adc_pkg;

  // Reader sequencing: wait for DRDY, shift a frame, accumulate, publish.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_ACCUM  = 2'd2,
    S_OUTPUT = 2'd3
  } adc_state_e;

  localparam int MAX_SCLK_DIV_POWER = 3;
  localparam int MAX_AVG_POWER      = 8;
  localparam int FRAME_COUNT_WIDTH  = 16;

endpackage

// File: rtl/adc_sclk_divider.sv
// Free-running divider producing SCLK and a one-cycle tick just before
// each SCLK falling edge. SCLK comes straight from a counter flop, so it
// is glitch-free.
module adc_sclk_divider #(
  parameter int DIV_POWER = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sclk_o,
  output logic fall_tick_o
);

  logic [DIV_POWER:0] cnt_q;

  // Counter wraps naturally; its top bit is SCLK.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  assign sclk_o      = cnt_q[DIV_POWER];
  // All ones: SCLK falls on the next clock edge, so sample now.
  assign fall_tick_o = &cnt_q;

endmodule

// File: rtl/adc_multichannel_reader.sv
// Reads NUM_CHANNELS serial ADC lines that share SCLK and DRDY_Bar,
// optionally box-car averages 2^AVG_POWER frames per channel and publishes
// one wide word with a single-cycle strobe. Everything runs on clk_50MHz;
// SCLK is only ever an output.
//
// Handshake: FLAG__New_Data is a one-cycle valid strobe with no ready;
// DATA is stable from that cycle until the next strobe.
module adc_multichannel_reader
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CHANNELS   = 2,
  parameter int SCLK_DIV_POWER = 0,
  parameter int AVG_POWER      = 0
) (
  input  logic                               clk_50MHz,
  input  logic                               reset,
  output logic                               CLK,
  output logic                               SCLK,
  input  logic                               DRDY_Bar,
  input  logic [NUM_CHANNELS-1:0]            DOUT,
  input  logic                               overrun_clear,
  output logic                               FLAG__New_Data,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] DATA,
  output logic                               overrun,
  output logic [FRAME_COUNT_WIDTH-1:0]       frame_count,
  output adc_state_e                         state_dbg
);

  localparam int ACC_W     = DATA_WIDTH + AVG_POWER;
  localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
  localparam int AVG_CNT_W = AVG_POWER + 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [AVG_CNT_W-1:0] LAST_AVG = AVG_CNT_W'((1 << AVG_POWER) - 1);

  logic                         sclk;
  logic                         fall_tick;
  logic                         drdy_meta_q, drdy_sync_q, drdy_prev_q;
  logic                         drdy_rise;
  logic                         shift_en;
  logic                         last_frame;
  adc_state_e                   state_q;
  logic [BIT_CNT_W-1:0]         bit_cnt_q;
  logic [AVG_CNT_W-1:0]         avg_cnt_q;
  logic                         flag_q;
  logic                         overrun_q;
  logic [FRAME_COUNT_WIDTH-1:0] frame_cnt_q;

  adc_sclk_divider #(
    .DIV_POWER(SCLK_DIV_POWER)
  ) u_div (
    .clk_i      (clk_50MHz),
    .rst_i      (reset),
    .sclk_o     (sclk),
    .fall_tick_o(fall_tick)
  );

  // Two-flop synchroniser, plus the value seen at the previous fall_tick.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      drdy_meta_q <= 1'b0;
      drdy_sync_q <= 1'b0;
      drdy_prev_q <= 1'b0;
    end else begin
      drdy_meta_q <= DRDY_Bar;
      drdy_sync_q <= drdy_meta_q;
      if (fall_tick) drdy_prev_q <= drdy_sync_q;
    end
  end

  assign drdy_rise  = fall_tick && drdy_sync_q && !drdy_prev_q;
  assign shift_en   = ((state_q == S_IDLE) && drdy_rise) ||
                      ((state_q == S_READ) && fall_tick);
  assign last_frame = (state_q == S_ACCUM) && (avg_cnt_q == LAST_AVG);

  // Frame sequencing, averaging count, strobe, overrun and frame counter.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      avg_cnt_q   <= '0;
      flag_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      flag_q <= 1'b0;
      // A new DRDY edge mid-frame wins over a simultaneous clear.
      if ((state_q == S_READ) && drdy_rise) overrun_q <= 1'b1;
      else if (overrun_clear)               overrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (drdy_rise) begin
            bit_cnt_q <= BIT_CNT_W'(1);
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          if (fall_tick) begin
            if (bit_cnt_q == LAST_BIT) state_q <= S_ACCUM;
            else                       bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_ACCUM: begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
          if (last_frame) begin
            // DATA is loaded on this edge, so the strobe lines up with OUTPUT.
            flag_q    <= 1'b1;
            avg_cnt_q <= '0;
            state_q   <= S_OUTPUT;
          end else begin
            avg_cnt_q <= avg_cnt_q + 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] frame_sx;
    logic signed [ACC_W-1:0] acc_sum;

    assign frame_sx = ACC_W'($signed(shift_q));
    assign acc_sum  = acc_q + frame_sx;

    // MSB-first shift, sign-extended accumulation, floor-divided publish.
    always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
        shift_q <= '0;
        data_q  <= '0;
        acc_q   <= '0;
      end else begin
        if (shift_en) shift_q <= {shift_q[DATA_WIDTH-2:0], DOUT[ch]};
        if (state_q == S_ACCUM) begin
          if (last_frame) begin
            data_q <= DATA_WIDTH'(acc_sum >>> AVG_POWER);
            acc_q  <= '0;
          end else begin
            acc_q  <= acc_sum;
          end
        end
      end
    end

    assign DATA[ch*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

  assign SCLK           = sclk;
  assign CLK            = sclk;
  assign FLAG__New_Data = flag_q;
  assign overrun        = overrun_q;
  assign frame_count    = frame_cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_adc_multichannel_reader.sv
// Directed bench for adc_multichannel_reader. Three instances:
// 0 = defaults, 1 = AVG_POWER 2, 2 = SCLK_DIV_POWER 1.
module tb_adc_multichannel_reader;
  import adc_pkg::*;

  localparam int CLK_NS = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #(CLK_NS/2) clk = ~clk;

  logic       rst_v  [3];
  logic       drdy_v [3];
  logic [1:0] dout_v [3];
  logic       oclr_v [3];

  logic        clk_o0, clk_o1, clk_o2;
  logic        sclk0, sclk1, sclk2;
  logic        flag0, flag1, flag2;
  logic        ovr0, ovr1, ovr2;
  logic [31:0] data0, data1, data2;
  logic [15:0] fc0, fc1, fc2;
  adc_state_e  st0, st1, st2;

  logic        sclk_v [3];
  logic        clko_v [3];
  logic        flag_v [3];
  logic        ovr_v  [3];
  logic [31:0] data_v [3];
  logic [15:0] fc_v   [3];
  adc_state_e  st_v   [3];

  always_comb begin
    sclk_v[0] = sclk0;  sclk_v[1] = sclk1;  sclk_v[2] = sclk2;
    clko_v[0] = clk_o0; clko_v[1] = clk_o1; clko_v[2] = clk_o2;
    flag_v[0] = flag0;  flag_v[1] = flag1;  flag_v[2] = flag2;
    ovr_v[0]  = ovr0;   ovr_v[1]  = ovr1;   ovr_v[2]  = ovr2;
    data_v[0] = data0;  data_v[1] = data1;  data_v[2] = data2;
    fc_v[0]   = fc0;    fc_v[1]   = fc1;    fc_v[2]   = fc2;
    st_v[0]   = st0;    st_v[1]   = st1;    st_v[2]   = st2;
  end

  adc_multichannel_reader u_dut_base (
    .clk_50MHz(clk), .reset(rst_v[0]), .CLK(clk_o0), .SCLK(sclk0),
    .DRDY_Bar(drdy_v[0]), .DOUT(dout_v[0]), .overrun_clear(oclr_v[0]),
    .FLAG__New_Data(flag0), .DATA(data0), .overrun(ovr0),
    .frame_count(fc0), .state_dbg(st0)
  );

  adc_multichannel_reader #(.AVG_POWER(2)) u_dut_avg (
    .clk_50MHz(clk), .reset(rst_v[1]), .CLK(clk_o1), .SCLK(sclk1),
    .DRDY_Bar(drdy_v[1]), .DOUT(dout_v[1]), .overrun_clear(oclr_v[1]),
    .FLAG__New_Data(flag1), .DATA(data1), .overrun(ovr1),
    .frame_count(fc1), .state_dbg(st1)
  );

  adc_multichannel_reader #(.SCLK_DIV_POWER(1)) u_dut_div (
    .clk_50MHz(clk), .reset(rst_v[2]), .CLK(clk_o2), .SCLK(sclk2),
    .DRDY_Bar(drdy_v[2]), .DOUT(dout_v[2]), .overrun_clear(oclr_v[2]),
    .FLAG__New_Data(flag2), .DATA(data2), .overrun(ovr2),
    .frame_count(fc2), .state_dbg(st2)
  );

  int tests = 0;
  int fails = 0;

  // Strobe and overrun-high cycle counters sampled on every clock edge.
  int flag_cnt [3] = '{0, 0, 0};
  int ovr_hi_cnt = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (flag_v[i] === 1'b1) flag_cnt[i] <= flag_cnt[i] + 1;
    if (ovr_v[0] === 1'b1) ovr_hi_cnt <= ovr_hi_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  // Returns 1ns after the clock edge on which SCLK of instance u moved to want.
  task automatic wait_edge(input int u, input logic want, output bit ok);
    logic prev, cur;
    ok   = 1'b0;
    prev = sclk_v[u];
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      cur = sclk_v[u];
      if (cur === want && prev !== want) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL sclk_edge u=%0d: no SCLK edge to %0b within 64 clocks", u, want);
    end
  endtask

  // ADC model: DRDY rises mid SCLK-high, bits change just after each SCLK fall.
  // ovr pulses DRDY low/high mid-frame; abort_bit >= 0 resets the DUT there.
  task automatic send_frame(input int u, input logic [15:0] ch0, input logic [15:0] ch1,
                            input bit ovr, input int abort_bit, output bit aborted);
    bit ok;
    aborted   = 1'b0;
    drdy_v[u] = 1'b0;
    dout_v[u] = 2'b00;
    repeat (3) wait_edge(u, 1'b0, ok);
    wait_edge(u, 1'b1, ok);
    drdy_v[u] = 1'b1;
    for (int b = 15; b >= 0; b--) begin
      wait_edge(u, 1'b0, ok);
      if (b == abort_bit) begin
        drdy_v[u] = 1'b0;
        rst_v[u]  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[u]  = 1'b0;
        aborted   = 1'b1;
        return;
      end
      dout_v[u] = {ch1[b], ch0[b]};
      if (ovr && b == 12) drdy_v[u] = 1'b0;
      if (ovr && b == 8)  drdy_v[u] = 1'b1;
    end
    wait_edge(u, 1'b0, ok);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      tests++; if (data_v[u] !== 32'h0) begin fails++; $display("FAIL reset_data u=%0d: got %h want 00000000", u, data_v[u]); end
      tests++; if (flag_v[u] !== 1'b0) begin fails++; $display("FAIL reset_flag u=%0d: got %b want 0", u, flag_v[u]); end
      tests++; if (ovr_v[u] !== 1'b0) begin fails++; $display("FAIL reset_overrun u=%0d: got %b want 0", u, ovr_v[u]); end
      tests++; if (fc_v[u] !== 16'h0) begin fails++; $display("FAIL reset_frame_count u=%0d: got %h want 0000", u, fc_v[u]); end
      tests++; if (sclk_v[u] !== 1'b0 || clko_v[u] !== 1'b0) begin fails++; $display("FAIL reset_sclk u=%0d: got SCLK=%b CLK=%b want 0/0", u, sclk_v[u], clko_v[u]); end
      tests++; if (st_v[u] !== S_IDLE) begin fails++; $display("FAIL reset_state u=%0d: got %0d want %0d", u, st_v[u], S_IDLE); end
    end
  endtask

  task automatic test_single_frame();
    bit ab;
    int base;
    base = flag_cnt[0];
    send_frame(0, 16'hA5C3, 16'h1234, 1'b0, -1, ab);
    @(posedge clk); #1;
    tests++; if (flag_v[0] !== 1'b1) begin fails++; $display("FAIL single_flag_latency: got %b want 1", flag_v[0]); end
    tests++; if (data_v[0] !== 32'h1234A5C3) begin fails++; $display("FAIL single_data: got %h want 1234a5c3", data_v[0]); end
    tests++; if (fc_v[0] !== 16'd1) begin fails++; $display("FAIL single_frame_count: got %0d want 1", fc_v[0]); end
    @(posedge clk); #1;
    tests++; if (flag_v[0] !== 1'b0) begin fails++; $display("FAIL single_flag_width: got %b want 0", flag_v[0]); end
    tests++; if (data_v[0] !== 32'h1234A5C3) begin fails++; $display("FAIL single_data_hold: got %h want 1234a5c3", data_v[0]); end
    tests++; if (flag_cnt[0] - base !== 1) begin fails++; $display("FAIL single_strobe_count: got %0d want 1", flag_cnt[0] - base); end
    tests++; if (ovr_v[0] !== 1'b0) begin fails++; $display("FAIL single_overrun: got %b want 0", ovr_v[0]); end
  endtask

  task automatic test_average(input int set);
    logic [15:0] c0 [4];
    logic [15:0] c1 [4];
    logic [31:0] exp_data;
    logic        exp_flag;
    int          base;
    bit          ab;
    if (set == 0) begin
      c0 = '{16'd100, 16'd200, 16'd300, 16'd400};
      c1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      exp_data = 32'hFFFF_00FA;
    end else begin
      c0 = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFD};
      c1 = '{16'd1, 16'd2, 16'd3, 16'd5};
      exp_data = 32'h0002_FFFC;
    end
    base = flag_cnt[1];
    for (int i = 0; i < 4; i++) begin
      send_frame(1, c0[i], c1[i], 1'b0, -1, ab);
      @(posedge clk); #1;
      exp_flag = (i == 3);
      tests++; if (flag_v[1] !== exp_flag) begin fails++; $display("FAIL avg%0d_flag frame=%0d: got %b want %b", set, i, flag_v[1], exp_flag); end
      if (i == 3) begin
        tests++; if (data_v[1] !== exp_data) begin fails++; $display("FAIL avg%0d_data: got %h want %h", set, data_v[1], exp_data); end
      end
    end
    @(posedge clk); #1;
    tests++; if (flag_cnt[1] - base !== 1) begin fails++; $display("FAIL avg%0d_strobe_count: got %0d want 1", set, flag_cnt[1] - base); end
    tests++; if (fc_v[1] !== 16'(4 * (set + 1))) begin fails++; $display("FAIL avg%0d_frame_count: got %0d want %0d", set, fc_v[1], 4 * (set + 1)); end
  endtask

  task automatic test_overrun();
    bit ab;
    send_frame(0, 16'h5A5A, 16'h0F0F, 1'b1, -1, ab);
    @(posedge clk); #1;
    tests++; if (flag_v[0] !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", flag_v[0]); end
    tests++; if (data_v[0] !== 32'h0F0F5A5A) begin fails++; $display("FAIL ovr_data: got %h want 0f0f5a5a", data_v[0]); end
    tests++; if (fc_v[0] !== 16'd2) begin fails++; $display("FAIL ovr_frame_count: got %0d want 2", fc_v[0]); end
    @(posedge clk); #1;
    tests++; if (ovr_v[0] !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", ovr_v[0]); end
    oclr_v[0] = 1'b1;
    @(posedge clk); #1;
    oclr_v[0] = 1'b0;
    tests++; if (ovr_v[0] !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", ovr_v[0]); end
  endtask

  task automatic test_overrun_priority();
    bit ab;
    int base;
    base = ovr_hi_cnt;
    oclr_v[0] = 1'b1;
    send_frame(0, 16'h0001, 16'h8000, 1'b1, -1, ab);
    @(posedge clk); #1;
    tests++; if (data_v[0] !== 32'h80000001) begin fails++; $display("FAIL prio_data: got %h want 80000001", data_v[0]); end
    tests++; if (fc_v[0] !== 16'd3) begin fails++; $display("FAIL prio_frame_count: got %0d want 3", fc_v[0]); end
    tests++; if (ovr_hi_cnt - base !== 1) begin fails++; $display("FAIL prio_set_wins: overrun high %0d cycles want 1", ovr_hi_cnt - base); end
    tests++; if (ovr_v[0] !== 1'b0) begin fails++; $display("FAIL prio_after_clear: got %b want 0", ovr_v[0]); end
    oclr_v[0] = 1'b0;
  endtask

  task automatic test_sclk_divider();
    bit  ok;
    time t0, t1;
    wait_edge(2, 1'b0, ok);
    t0 = $time;
    wait_edge(2, 1'b0, ok);
    t1 = $time;
    tests++; if (t1 - t0 !== time'(4 * CLK_NS)) begin fails++; $display("FAIL div_period: got %0t want %0d", t1 - t0, 4 * CLK_NS); end
    wait_edge(2, 1'b1, ok);
    t0 = $time;
    tests++; if (clko_v[2] !== 1'b1) begin fails++; $display("FAIL div_clk_high: CLK=%b want 1", clko_v[2]); end
    wait_edge(2, 1'b0, ok);
    t1 = $time;
    tests++; if (t1 - t0 !== time'(2 * CLK_NS)) begin fails++; $display("FAIL div_high_time: got %0t want %0d", t1 - t0, 2 * CLK_NS); end
    tests++; if (clko_v[2] !== 1'b0) begin fails++; $display("FAIL div_clk_low: CLK=%b want 0", clko_v[2]); end
  endtask

  task automatic test_reset_mid_frame();
    bit ab;
    int base;
    send_frame(2, 16'h1357, 16'h2468, 1'b0, -1, ab);
    @(posedge clk); #1;
    tests++; if (flag_v[2] !== 1'b1 || data_v[2] !== 32'h24681357) begin fails++; $display("FAIL div_frame: flag=%b data=%h want 1/24681357", flag_v[2], data_v[2]); end
    tests++; if (fc_v[2] !== 16'd1) begin fails++; $display("FAIL div_frame_count: got %0d want 1", fc_v[2]); end
    base = flag_cnt[2] + 1;
    send_frame(2, 16'hFFFF, 16'hFFFF, 1'b0, 10, ab);
    repeat (4) @(posedge clk);
    #1;
    tests++; if (fc_v[2] !== 16'd0) begin fails++; $display("FAIL abort_frame_count: got %0d want 0", fc_v[2]); end
    tests++; if (data_v[2] !== 32'h0) begin fails++; $display("FAIL abort_data: got %h want 00000000", data_v[2]); end
    tests++; if (st_v[2] !== S_IDLE) begin fails++; $display("FAIL abort_state: got %0d want %0d", st_v[2], S_IDLE); end
    tests++; if (flag_cnt[2] !== base) begin fails++; $display("FAIL abort_no_strobe: strobes %0d want %0d", flag_cnt[2], base); end
    send_frame(2, 16'h00FF, 16'h0000, 1'b0, -1, ab);
    @(posedge clk); #1;
    tests++; if (flag_v[2] !== 1'b1) begin fails++; $display("FAIL post_abort_flag: got %b want 1", flag_v[2]); end
    tests++; if (data_v[2] !== 32'h000000FF) begin fails++; $display("FAIL post_abort_data: got %h want 000000ff", data_v[2]); end
    tests++; if (fc_v[2] !== 16'd1) begin fails++; $display("FAIL post_abort_frame_count: got %0d want 1", fc_v[2]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int u = 0; u < 3; u++) begin
      rst_v[u]  = 1'b1;
      drdy_v[u] = 1'b0;
      dout_v[u] = 2'b00;
      oclr_v[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    for (int u = 0; u < 3; u++) rst_v[u] = 1'b0;
    test_single_frame();
    test_average(0);
    test_average(1);
    test_overrun();
    test_overrun_priority();
    test_sclk_divider();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
